// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch -- front end of the DLX pipeline.
//
// Holds the word-addressed PC and fetches from instruction memory over a
// variable-latency req/ack handshake. The fetched word goes into the IF/ID
// register (instruc, current_PC, if_valid) that feeds decode. Decode can
// stall the stage or redirect it with branch_sel/jump_address.
//
// Ports:
//   clock, reset_n       single rising-edge clock, async active-low reset
//   imem_req/imem_addr   fetch request and its word address
//   imem_ack/imem_rdata  one-cycle completion pulse with the fetched word
//   id_stall             decode cannot accept a new instruction
//   branch_sel           redirect request from decode
//   jump_address         redirect target
//   instruc              IF/ID instruction word
//   current_PC           address of instruc plus one
//   if_valid             IF/ID holds a real instruction
//
// Optional feature: define BRANCH_DELAY_SLOT_EN to keep the delay-slot
// instruction after a taken branch instead of flushing it.
// ----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int unsigned         PC_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC = 10'd0,
    parameter logic [31:0]         NOP_WORD = 32'h0000_0000
) (
    input  logic                clock,
    input  logic                reset_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    input  logic                id_stall,
    input  logic                branch_sel,
    input  logic [PC_WIDTH-1:0] jump_address,
    output logic [31:0]         instruc,
    output logic [PC_WIDTH-1:0] current_PC,
    output logic                if_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    // Address of the request on the bus; kept separate from pc_q so a
    // redirect never changes imem_addr while imem_req is high.
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]         instruc_q, instruc_d;
    logic [PC_WIDTH-1:0] cur_pc_q, cur_pc_d;
    logic                valid_q, valid_d;
    logic                squash_q, squash_d;
    logic [31:0]         skid_q, skid_d;
`ifdef BRANCH_DELAY_SLOT_EN
    logic                pend_q, pend_d;
    logic [PC_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
`endif

    logic                redirect_s;
    logic                load_ok_s;
    logic [PC_WIDTH-1:0] fetch_next_s;

    assign redirect_s   = branch_sel & valid_q & ~id_stall;
    assign load_ok_s    = ~valid_q | ~id_stall;
    // addr_q is the address of the word being accepted (in REQ and HOLD).
    assign fetch_next_s = addr_q + PC_ONE;

    // Next-state and IF/ID update logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        instruc_d = instruc_q;
        cur_pc_d  = cur_pc_q;
        valid_d   = valid_q;
        squash_d  = squash_q;
        skid_d    = skid_q;
`ifdef BRANCH_DELAY_SLOT_EN
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                addr_d  = pc_q;
            end
            ST_REQ: begin
                if (redirect_s) begin
`ifdef BRANCH_DELAY_SLOT_EN
                    if (imem_ack) begin
                        // Delay-slot word arrives now: keep it, then go to target.
                        instruc_d = imem_rdata;
                        cur_pc_d  = fetch_next_s;
                        valid_d   = 1'b1;
                        pc_d      = jump_address;
                        addr_d    = jump_address;
                    end else begin
                        // Delay slot still outstanding: remember the target.
                        instruc_d  = NOP_WORD;
                        valid_d    = 1'b0;
                        pend_d     = 1'b1;
                        pend_tgt_d = jump_address;
                    end
`else
                    instruc_d = NOP_WORD;
                    valid_d   = 1'b0;
                    pc_d      = jump_address;
                    if (imem_ack) begin
                        // Arriving word is dropped; next request goes to target.
                        addr_d   = jump_address;
                        squash_d = 1'b0;
                    end else begin
                        // In-flight request must finish at its old address.
                        squash_d = 1'b1;
                    end
`endif
                end else if (imem_ack) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        addr_d   = pc_q;
                    end else if (load_ok_s) begin
                        instruc_d = imem_rdata;
                        cur_pc_d  = fetch_next_s;
                        valid_d   = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
                        if (pend_q) begin
                            pend_d = 1'b0;
                            pc_d   = pend_tgt_q;
                            addr_d = pend_tgt_q;
                        end else begin
                            pc_d   = fetch_next_s;
                            addr_d = fetch_next_s;
                        end
`else
                        pc_d   = fetch_next_s;
                        addr_d = fetch_next_s;
`endif
                    end else begin
                        skid_d  = imem_rdata;
                        state_d = ST_HOLD;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect_s) begin
`ifdef BRANCH_DELAY_SLOT_EN
                    instruc_d = skid_q;
                    cur_pc_d  = fetch_next_s;
                    valid_d   = 1'b1;
`else
                    instruc_d = NOP_WORD;
                    valid_d   = 1'b0;
`endif
                    pc_d    = jump_address;
                    addr_d  = jump_address;
                    state_d = ST_REQ;
                end else if (!id_stall) begin
                    instruc_d = skid_q;
                    cur_pc_d  = fetch_next_s;
                    valid_d   = 1'b1;
                    pc_d      = fetch_next_s;
                    addr_d    = fetch_next_s;
                    state_d   = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and IF/ID registers with asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            instruc_q <= NOP_WORD;
            cur_pc_q  <= {PC_WIDTH{1'b0}};
            valid_q   <= 1'b0;
            squash_q  <= 1'b0;
            skid_q    <= 32'h0000_0000;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_q     <= 1'b0;
            pend_tgt_q <= {PC_WIDTH{1'b0}};
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            instruc_q <= instruc_d;
            cur_pc_q  <= cur_pc_d;
            valid_q   <= valid_d;
            squash_q  <= squash_d;
            skid_q    <= skid_d;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
`endif
        end
    end

    assign imem_req   = (state_q == ST_REQ);
    assign imem_addr  = addr_q;
    assign instruc    = instruc_q;
    assign current_PC = cur_pc_q;
    assign if_valid   = valid_q;

endmodule
